fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order PC tagging,
// kill-on-redirect of stale responses and a small instruction buffer toward decode.
module fetch_unit #(
  parameter logic [63:0] ResetPC  = 64'h0,
  parameter int unsigned BufDepth = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        imem_req_valid_o,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] instruction_o,
  output logic [63:0] PC_o,
  input  logic        ready_i
);

  localparam int unsigned CntW = $clog2(BufDepth + 1);
  localparam int unsigned PtrW = $clog2(BufDepth);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(BufDepth);
  localparam ptr_t          PtrLast  = ptr_t'(BufDepth - 1);

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == PtrLast) begin
      return {PtrW{1'b0}};
    end else begin
      return p + ptr_t'(1'b1);
    end
  endfunction

  logic [63:0] fetch_pc_r, fetch_pc_nxt_s;
  cnt_t        inflight_r, inflight_nxt_s;
  cnt_t        kill_r, kill_nxt_s;
  cnt_t        fifo_count_r, fifo_count_nxt_s;
  ptr_t        tag_wr_ptr_r, tag_wr_ptr_nxt_s;
  ptr_t        tag_rd_ptr_r, tag_rd_ptr_nxt_s;
  ptr_t        fifo_wr_ptr_r, fifo_wr_ptr_nxt_s;
  ptr_t        fifo_rd_ptr_r, fifo_rd_ptr_nxt_s;

  logic [63:0] tag_mem_r   [BufDepth];
  logic [63:0] pc_mem_r    [BufDepth];
  logic [31:0] instr_mem_r [BufDepth];

  logic [CntW:0] used_s;
  logic          req_fire_s;
  logic          rsp_s;
  logic          kill_active_s;
  logic          push_s;
  logic          pop_s;
  logic          unused_pc_bits_s;

  // Credits count both in-flight requests and buffered entries, so a response always has a slot
  assign used_s           = {1'b0, inflight_r} + {1'b0, fifo_count_r};
  assign imem_req_valid_o = reset_ni & ~redirect_i & (used_s < DepthCnt);
  assign imem_req_addr_o  = fetch_pc_r;
  assign req_fire_s       = imem_req_valid_o & imem_req_ready_i;
  assign rsp_s            = imem_rsp_valid_i;
  assign kill_active_s    = (kill_r != {CntW{1'b0}});
  assign push_s           = rsp_s & ~kill_active_s & ~redirect_i;
  assign valid_o          = (fifo_count_r != {CntW{1'b0}}) & ~redirect_i;
  assign pop_s            = valid_o & ready_i;
  assign instruction_o    = instr_mem_r[fifo_rd_ptr_r];
  assign PC_o             = pc_mem_r[fifo_rd_ptr_r];
  assign unused_pc_bits_s = ^redirect_pc_i[1:0];

  // Next-state for fetch PC, counters and queue pointers
  always_comb begin
    fetch_pc_nxt_s    = fetch_pc_r;
    inflight_nxt_s    = inflight_r;
    kill_nxt_s        = kill_r;
    fifo_count_nxt_s  = fifo_count_r;
    tag_wr_ptr_nxt_s  = tag_wr_ptr_r;
    tag_rd_ptr_nxt_s  = tag_rd_ptr_r;
    fifo_wr_ptr_nxt_s = fifo_wr_ptr_r;
    fifo_rd_ptr_nxt_s = fifo_rd_ptr_r;

    if (rsp_s) begin
      tag_rd_ptr_nxt_s = ptr_inc(tag_rd_ptr_r);
    end else begin
      tag_rd_ptr_nxt_s = tag_rd_ptr_r;
    end

    if (redirect_i) begin
      // Everything still outstanding after this cycle's response belongs to the old path
      fetch_pc_nxt_s    = {redirect_pc_i[63:2], 2'b00};
      inflight_nxt_s    = inflight_r - cnt_t'(rsp_s);
      kill_nxt_s        = inflight_r - cnt_t'(rsp_s);
      fifo_count_nxt_s  = {CntW{1'b0}};
      fifo_rd_ptr_nxt_s = fifo_wr_ptr_r;
    end else begin
      if (req_fire_s) begin
        fetch_pc_nxt_s   = fetch_pc_r + 64'd4;
        tag_wr_ptr_nxt_s = ptr_inc(tag_wr_ptr_r);
      end else begin
        fetch_pc_nxt_s   = fetch_pc_r;
        tag_wr_ptr_nxt_s = tag_wr_ptr_r;
      end
      inflight_nxt_s = inflight_r + cnt_t'(req_fire_s) - cnt_t'(rsp_s);
      if (rsp_s && kill_active_s) begin
        kill_nxt_s = kill_r - cnt_t'(1'b1);
      end else begin
        kill_nxt_s = kill_r;
      end
      fifo_count_nxt_s = fifo_count_r + cnt_t'(push_s) - cnt_t'(pop_s);
      if (push_s) begin
        fifo_wr_ptr_nxt_s = ptr_inc(fifo_wr_ptr_r);
      end else begin
        fifo_wr_ptr_nxt_s = fifo_wr_ptr_r;
      end
      if (pop_s) begin
        fifo_rd_ptr_nxt_s = ptr_inc(fifo_rd_ptr_r);
      end else begin
        fifo_rd_ptr_nxt_s = fifo_rd_ptr_r;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fetch_pc_r    <= ResetPC;
      inflight_r    <= {CntW{1'b0}};
      kill_r        <= {CntW{1'b0}};
      fifo_count_r  <= {CntW{1'b0}};
      tag_wr_ptr_r  <= {PtrW{1'b0}};
      tag_rd_ptr_r  <= {PtrW{1'b0}};
      fifo_wr_ptr_r <= {PtrW{1'b0}};
      fifo_rd_ptr_r <= {PtrW{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      inflight_r    <= inflight_nxt_s;
      kill_r        <= kill_nxt_s;
      fifo_count_r  <= fifo_count_nxt_s;
      tag_wr_ptr_r  <= tag_wr_ptr_nxt_s;
      tag_rd_ptr_r  <= tag_rd_ptr_nxt_s;
      fifo_wr_ptr_r <= fifo_wr_ptr_nxt_s;
      fifo_rd_ptr_r <= fifo_rd_ptr_nxt_s;
    end
  end

  // Tag and instruction storage; contents are don't-care until their counters cover them
  always_ff @(posedge clk_i) begin
    if (req_fire_s) begin
      tag_mem_r[tag_wr_ptr_r] <= fetch_pc_r;
    end
    if (push_s) begin
      pc_mem_r[fifo_wr_ptr_r]    <= tag_mem_r[tag_rd_ptr_r];
      instr_mem_r[fifo_wr_ptr_r] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model, 1-cycle memory model,
// per-cycle output comparison plus hand-computed PC expectations per scenario.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'h0;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic [63:0] PC_o;
  logic        ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.ResetPC(RST_PC), .BufDepth(DEPTH)) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .valid_o          (valid_o),
    .instruction_o    (instruction_o),
    .PC_o             (PC_o),
    .ready_i          (ready_i)
  );

  int vectors = 0;
  int miscompares = 0;

  logic        rst_val = 1'b0;
  logic        mem_hold = 1'b0;
  logic        drv_ready = 1'b1;
  logic        drv_req_ready = 1'b1;
  logic        drv_redirect = 1'b0;
  logic [63:0] drv_redirect_pc = 64'h0;

  // reference model state
  logic [63:0] m_pc = RST_PC;
  int          m_inflight = 0;
  int          m_kill = 0;
  logic [63:0] m_tags[$];
  logic [63:0] m_fifo[$];

  logic [63:0] mem_q[$];
  logic [63:0] out_log[$];
  int          acc_count = 0;
  logic        last_req_valid;
  logic [63:0] last_req_addr;

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [63:0] exp);
    if (idx < out_log.size()) begin
      check64(name, out_log[idx], exp);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: only %0d transfers seen, expected PC %h at index %0d",
               name, out_log.size(), exp, idx);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT with model, then advance model and memory
  task automatic step();
    logic        m_req_valid;
    logic        m_valid;
    logic        rsp;
    logic [63:0] t;
    @(posedge clk_i);
    #1;
    reset_ni         = rst_val;
    ready_i          = drv_ready;
    imem_req_ready_i = drv_req_ready;
    redirect_i       = drv_redirect;
    redirect_pc_i    = drv_redirect_pc;
    if (!rst_val) mem_q.delete();
    if (mem_q.size() > 0 && !mem_hold) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ins_of(mem_q[0]);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
    end
    #3;
    last_req_valid = imem_req_valid_o;
    last_req_addr  = imem_req_addr_o;
    if (!rst_val) begin
      check1("reset_req_valid", imem_req_valid_o, 1'b0);
      check1("reset_valid", valid_o, 1'b0);
      m_pc = RST_PC;
      m_inflight = 0;
      m_kill = 0;
      m_tags.delete();
      m_fifo.delete();
    end else begin
      m_req_valid = !drv_redirect && ((m_inflight + m_fifo.size()) < DEPTH);
      m_valid     = (m_fifo.size() > 0) && !drv_redirect;
      check1("req_valid", imem_req_valid_o, m_req_valid);
      if (m_req_valid) check64("req_addr", imem_req_addr_o, m_pc);
      check1("valid", valid_o, m_valid);
      if (m_valid) begin
        check64("pc_out", PC_o, m_fifo[0]);
        check32("instr_out", instruction_o, ins_of(m_fifo[0]));
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        mem_q.push_back(imem_req_addr_o);
        acc_count++;
      end
      if (valid_o && ready_i) out_log.push_back(PC_o);

      rsp = imem_rsp_valid_i;
      if (drv_redirect) begin
        if (rsp) begin
          if (m_tags.size() > 0) void'(m_tags.pop_front());
          m_inflight--;
        end
        m_kill = m_inflight;
        m_fifo.delete();
        m_pc = {drv_redirect_pc[63:2], 2'b00};
      end else begin
        if (m_valid && drv_ready) void'(m_fifo.pop_front());
        if (rsp) begin
          t = (m_tags.size() > 0) ? m_tags.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
          m_inflight--;
          if (m_kill > 0) m_kill--;
          else m_fifo.push_back(t);
        end
        if (m_req_valid && drv_req_ready) begin
          m_tags.push_back(m_pc);
          m_pc = m_pc + 64'd4;
          m_inflight++;
        end
      end
    end
  endtask

  initial begin
    // reset, then streaming with 1-cycle memory
    rst_val = 1'b0;
    repeat (2) step();
    rst_val = 1'b1;
    step();
    check1("first_req_valid", last_req_valid, 1'b1);
    check64("first_req_addr", last_req_addr, 64'h0000_0000_0000_1000);
    repeat (14) step();
    check_log("stream_pc0", 0, 64'h1000);
    check_log("stream_pc1", 1, 64'h1004);
    check_log("stream_pc2", 2, 64'h1008);
    check_log("stream_pc3", 3, 64'h100C);

    // downstream backpressure from reset
    out_log.delete();
    rst_val = 1'b0;
    step();
    rst_val = 1'b1;
    drv_ready = 1'b0;
    acc_count = 0;
    repeat (10) step();
    check_int("bp_requests", acc_count, 2);
    check1("bp_valid_held", valid_o, 1'b1);
    check64("bp_head_pc", PC_o, 64'h1000);
    check_int("bp_no_transfer", out_log.size(), 0);
    drv_ready = 1'b1;
    repeat (8) step();
    check_log("bp_drain0", 0, 64'h1000);
    check_log("bp_drain1", 1, 64'h1004);
    check_log("bp_drain2", 2, 64'h1008);

    // redirect with two requests outstanding
    mem_hold = 1'b1;
    repeat (4) step();
    out_log.delete();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h2002;
    step();
    check1("redir_no_req", last_req_valid, 1'b0);
    drv_redirect = 1'b0;
    mem_hold = 1'b0;
    repeat (10) step();
    check_log("redir_pc0", 0, 64'h2000);
    check_log("redir_pc1", 1, 64'h2004);

    // request stall after redirect
    out_log.delete();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h3000;
    step();
    drv_redirect = 1'b0;
    drv_req_ready = 1'b0;
    repeat (5) begin
      step();
      if (last_req_valid) check64("stall_addr", last_req_addr, 64'h3000);
    end
    check1("stall_req_pending", last_req_valid, 1'b1);
    check64("stall_addr_final", last_req_addr, 64'h3000);
    drv_req_ready = 1'b1;
    repeat (6) step();
    check_log("stall_pc0", 0, 64'h3000);
    check_log("stall_pc1", 1, 64'h3004);

    // address wrap
    out_log.delete();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    drv_redirect = 1'b0;
    repeat (10) step();
    check_log("wrap_pc0", 0, 64'hFFFF_FFFF_FFFF_FFFC);
    check_log("wrap_pc1", 1, 64'h0000_0000_0000_0000);
    check_log("wrap_pc2", 2, 64'h0000_0000_0000_0004);

    // back-to-back redirects, last one wins
    out_log.delete();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h4000;
    step();
    drv_redirect_pc = 64'h5001;
    step();
    drv_redirect = 1'b0;
    repeat (8) step();
    check_log("b2b_pc0", 0, 64'h5000);
    check_log("b2b_pc1", 1, 64'h5004);

    // reset mid-stream with two outstanding
    mem_hold = 1'b1;
    repeat (4) step();
    out_log.delete();
    rst_val = 1'b0;
    step();
    rst_val = 1'b1;
    mem_hold = 1'b0;
    step();
    check1("rst_restart_valid", last_req_valid, 1'b1);
    check64("rst_restart_addr", last_req_addr, 64'h1000);
    repeat (8) step();
    check_log("rst_pc0", 0, 64'h1000);
    check_log("rst_pc1", 1, 64'h1004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
